// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: redirect/stall from decode-execute, memory
// request/acknowledge, and the decode-facing head-of-queue outputs.
// master = fetch stage, slave = memory plus decode side.
interface fetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  // redirect / decode backpressure
  logic                  i_flush;
  logic [ADDR_WIDTH-1:0] i_flush_pc;
  logic                  i_stall;
  // instruction memory
  logic                  o_mem_req;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_write;
  logic                  i_mem_ack;
  logic [WORD_WIDTH-1:0] i_mem_data;
  // decode-facing
  logic [ADDR_WIDTH-1:0] o_next_pc;
  logic                  o_valid;
  logic [WORD_WIDTH-1:0] o_inst;
  logic [ADDR_WIDTH-1:0] o_inst_pc;

  modport master (
    input  i_flush, i_flush_pc, i_stall, i_mem_ack, i_mem_data,
    output o_mem_req, o_mem_addr, o_mem_write, o_next_pc,
           o_valid, o_inst, o_inst_pc
  );

  modport slave (
    output i_flush, i_flush_pc, i_stall, i_mem_ack, i_mem_data,
    input  o_mem_req, o_mem_addr, o_mem_write, o_next_pc,
           o_valid, o_inst, o_inst_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch with internal PC, one-outstanding memory requests and a DEPTH-entry prefetch queue.
// Latency: request at T, ack at T+L, entry on o_valid at T+L+1; L=1 sustains one instruction per cycle.
// Backpressure: i_stall holds the head; requests stop once queued + in-flight entries reach DEPTH.
//
// Ports: i_clk, i_rst (sync, active-high); bus (fetch_queue_if.master) carries
// flush/redirect, stall, memory req/addr/ack/data, next PC and the queue head.
module fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    WORD_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WORD_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  outstanding;
  logic                  drop;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
  logic [WORD_WIDTH-1:0] q_inst [DEPTH];

  logic       head_vld;
  logic       mem_req;
  logic       rsp_ack;
  logic       push;
  logic       pop;
  logic [CW:0] occupancy;

  always_comb begin
    // The in-flight request already owns a queue slot.
    occupancy = {1'b0, count} + {{CW{1'b0}}, outstanding};
    head_vld  = (count != '0);
    rsp_ack   = bus.i_mem_ack && outstanding;
    // A new request may go out in the ack cycle of the previous one, but
    // never on the ack of a response that is being dropped.
    mem_req   = !i_rst && !bus.i_flush &&
                (!outstanding || (bus.i_mem_ack && !drop)) &&
                (occupancy < (CW+1)'(DEPTH));
    push      = !i_rst && rsp_ack && !drop && !bus.i_flush;
    pop       = head_vld && !bus.i_stall && !bus.i_flush;
  end

  // Control state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (bus.i_flush) begin
      fetch_pc <= bus.i_flush_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if (outstanding) begin
        if (bus.i_mem_ack) begin
          // Response arriving with the flush is simply thrown away.
          outstanding <= 1'b0;
          drop        <= 1'b0;
        end else begin
          // Still in flight: remember to discard it when it lands.
          drop <= 1'b1;
        end
      end
    end else begin
      if (mem_req) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + STEP;
        drop        <= 1'b0;
      end else if (rsp_ack) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only observed through count, so no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_inst[wr_ptr] <= bus.i_mem_data;
    end
  end

  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_addr  = fetch_pc;
  assign bus.o_mem_write = 1'b0;
  assign bus.o_next_pc   = fetch_pc;
  assign bus.o_valid     = head_vld;
  assign bus.o_inst      = head_vld ? q_inst[rd_ptr] : '0;
  assign bus.o_inst_pc   = head_vld ? q_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int AW = 32;
  localparam int WW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  fetch_queue_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  fetch_queue #(
    .ADDR_WIDTH(AW),
    .WORD_WIDTH(WW),
    .DEPTH     (4),
    .RESET_PC  (32'h0)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int lat      = 1;
  bit manual   = 1'b0;
  int nreq;

  logic        m_ack    = 1'b0;
  logic [31:0] m_data   = '0;
  logic [31:0] pend     = '0;
  int          remain   = 0;
  logic        man_ack  = 1'b0;
  logic [31:0] man_data = '0;

  assign bus.i_mem_ack  = manual ? man_ack  : m_ack;
  assign bus.i_mem_data = manual ? man_data : m_data;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory with fixed latency 'lat' (one request at a time).
  always begin : mem_model
    logic        req_s;
    logic [31:0] addr_s;
    @(posedge clk);
    req_s  = bus.o_mem_req;
    addr_s = bus.o_mem_addr;
    #1;
    m_ack = 1'b0;
    if (manual) begin
      remain = 0;
    end else begin
      if (remain > 0) begin
        remain = remain - 1;
        if (remain == 0) begin
          m_ack  = 1'b1;
          m_data = inst_of(pend);
        end
      end
      if (req_s) begin
        pend   = addr_s;
        remain = lat - 1;
        if (remain == 0) begin
          m_ack  = 1'b1;
          m_data = inst_of(addr_s);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst            = 1'b1;
    bus.i_flush    = 1'b0;
    bus.i_flush_pc = '0;
    bus.i_stall    = 1'b0;
    lat            = 1;

    // ---- reset values
    tick();
    tick();
    chk("rst_valid",   bus.o_valid,     0);
    chk("rst_inst",    bus.o_inst,      0);
    chk("rst_inst_pc", bus.o_inst_pc,   0);
    chk("rst_req",     bus.o_mem_req,   0);
    chk("rst_write",   bus.o_mem_write, 0);
    chk("rst_next_pc", bus.o_next_pc,   0);

    // ---- L=1 streaming, no stall
    rst = 1'b0; #1;                           // cycle 1
    chk("s1_c1_req",  bus.o_mem_req,  1);
    chk("s1_c1_addr", bus.o_mem_addr, 32'h0);
    tick();                                   // cycle 2
    chk("s1_c2_req",   bus.o_mem_req,  1);
    chk("s1_c2_addr",  bus.o_mem_addr, 32'h4);
    chk("s1_c2_valid", bus.o_valid,    0);
    tick();                                   // cycle 3
    chk("s1_c3_valid", bus.o_valid,    1);
    chk("s1_c3_pc",    bus.o_inst_pc,  32'h0);
    chk("s1_c3_inst",  bus.o_inst,     32'hC0DE0000);
    chk("s1_c3_addr",  bus.o_mem_addr, 32'h8);
    tick();
    chk("s1_c4_pc", bus.o_inst_pc, 32'h4);
    tick();
    chk("s1_c5_pc", bus.o_inst_pc, 32'h8);
    chk("s1_write", bus.o_mem_write, 0);

    // ---- stall fills the queue, then drain across the pointer wrap
    rst = 1'b1; bus.i_stall = 1'b1;
    tick();
    rst = 1'b0; #1;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_mem_req) nreq++;
      tick();
    end
    chk("s2_nreq",     nreq,           4);
    chk("s2_req_off",  bus.o_mem_req,  0);
    chk("s2_held_pc",  bus.o_inst_pc,  32'h0);
    chk("s2_next_pc",  bus.o_next_pc,  32'h10);
    bus.i_stall = 1'b0; #1;
    chk("s2_a_pc",   bus.o_inst_pc,  32'h0);
    chk("s2_a_req",  bus.o_mem_req,  0);
    tick();
    chk("s2_a1_pc",   bus.o_inst_pc,  32'h4);
    chk("s2_a1_req",  bus.o_mem_req,  1);
    chk("s2_a1_addr", bus.o_mem_addr, 32'h10);
    tick();
    chk("s2_a2_pc",   bus.o_inst_pc,  32'h8);
    chk("s2_a2_addr", bus.o_mem_addr, 32'h14);
    tick();
    chk("s2_a3_pc", bus.o_inst_pc, 32'hC);
    tick();
    chk("s2_a4_pc",   bus.o_inst_pc, 32'h10);
    chk("s2_a4_inst", bus.o_inst,    32'hC0DE0010);
    tick();
    chk("s2_a5_pc", bus.o_inst_pc, 32'h14);
    tick();
    chk("s2_a6_pc", bus.o_inst_pc, 32'h18);

    // ---- L=3, flush with a request in flight
    rst = 1'b1; lat = 3;
    tick();
    rst = 1'b0; #1;                           // c1
    chk("s4_c1_req", bus.o_mem_req, 1);
    tick();                                   // c2
    chk("s4_c2_req", bus.o_mem_req, 0);
    tick();                                   // c3
    tick();                                   // c4
    chk("s4_c4_ack",  bus.i_mem_ack,  1);
    chk("s4_c4_req",  bus.o_mem_req,  1);
    chk("s4_c4_addr", bus.o_mem_addr, 32'h4);
    tick();                                   // c5
    chk("s4_c5_valid", bus.o_valid,   1);
    chk("s4_c5_pc",    bus.o_inst_pc, 32'h0);
    tick();                                   // c6
    tick();                                   // c7
    chk("s4_c7_req",  bus.o_mem_req,  1);
    chk("s4_c7_addr", bus.o_mem_addr, 32'h8);
    tick();                                   // c8: flush
    bus.i_flush = 1'b1; bus.i_flush_pc = 32'h100; #1;
    chk("s4_c8_req", bus.o_mem_req, 0);
    tick();                                   // c9
    bus.i_flush = 1'b0; #1;
    chk("s4_c9_valid",   bus.o_valid,   0);
    chk("s4_c9_next_pc", bus.o_next_pc, 32'h100);
    chk("s4_c9_req",     bus.o_mem_req, 0);
    tick();                                   // c10: dropped ack
    chk("s4_c10_ack",   bus.i_mem_ack, 1);
    chk("s4_c10_req",   bus.o_mem_req, 0);
    chk("s4_c10_valid", bus.o_valid,   0);
    tick();                                   // c11
    chk("s4_c11_req",  bus.o_mem_req,  1);
    chk("s4_c11_addr", bus.o_mem_addr, 32'h100);
    tick(); tick(); tick();                   // c14: ack 0x100, request 0x104
    bus.i_stall = 1'b1;
    tick();                                   // c15
    chk("s4_c15_valid", bus.o_valid,   1);
    chk("s4_c15_pc",    bus.o_inst_pc, 32'h100);
    chk("s4_c15_inst",  bus.o_inst,    32'hC0DE0100);

    // ---- flush in the same cycle as an ack
    tick();                                   // c16
    tick();                                   // c17: ack for 0x104
    bus.i_flush = 1'b1; bus.i_flush_pc = 32'h200; #1;
    chk("s5_c17_ack", bus.i_mem_ack, 1);
    chk("s5_c17_req", bus.o_mem_req, 0);
    tick();                                   // c18
    bus.i_flush = 1'b0; #1;
    chk("s5_c18_valid", bus.o_valid,    0);
    chk("s5_c18_req",   bus.o_mem_req,  1);
    chk("s5_c18_addr",  bus.o_mem_addr, 32'h200);
    tick(); tick(); tick(); tick();           // c22
    chk("s5_c22_valid", bus.o_valid,   1);
    chk("s5_c22_pc",    bus.o_inst_pc, 32'h200);

    // ---- reset with a request outstanding; stale ack afterwards
    manual = 1'b1; man_ack = 1'b0; rst = 1'b1; #1;
    chk("s6_rst_req", bus.o_mem_req, 0);
    tick();                                   // c23: stale ack
    rst = 1'b0; man_ack = 1'b1; man_data = 32'hBAD00204; #1;
    chk("s6_valid",   bus.o_valid,    0);
    chk("s6_inst",    bus.o_inst,     0);
    chk("s6_inst_pc", bus.o_inst_pc,  0);
    chk("s6_next_pc", bus.o_next_pc,  32'h0);
    chk("s6_req",     bus.o_mem_req,  1);
    chk("s6_addr",    bus.o_mem_addr, 32'h0);
    tick();                                   // c24
    man_ack = 1'b0; #1;
    chk("s6_stale_valid", bus.o_valid,   0);
    chk("s6_busy_req",    bus.o_mem_req, 0);
    tick();                                   // c25: real ack
    man_ack = 1'b1; man_data = 32'h12345678; #1;
    chk("s6_ack_req",  bus.o_mem_req,  1);
    chk("s6_ack_addr", bus.o_mem_addr, 32'h4);
    tick();                                   // c26
    man_ack = 1'b0; #1;
    chk("s6_head_valid", bus.o_valid,   1);
    chk("s6_head_pc",    bus.o_inst_pc, 32'h0);
    chk("s6_head_inst",  bus.o_inst,    32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with an internal program counter, a variable-latency memory request/acknowledge interface and a DEPTH-entry prefetch queue feeding decode. It replaces the single-register fetch stage: fetch runs ahead of a stalled decode, tolerates memory latency of one or more cycles, and redirects on a flush by discarding queued and in-flight instructions. Sits between instruction memory and decode; the PC-update logic in decode/execute drives the flush/redirect inputs.

## Interface
- ADDR_WIDTH, 32, byte-address width.
- WORD_WIDTH, 32, instruction width; multiple of 8; PC step = WORD_WIDTH/8.
- DEPTH, 4, queue entries; power of 2, >= 2.
- RESET_PC, 0, fetch address after reset.

- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_flush  in  1  discard queue and in-flight fetch; redirect fetch to i_flush_pc.
- i_flush_pc  in  ADDR_WIDTH  redirect target, sampled when i_flush=1.
- i_stall  in  1  decode not consuming; head entry held.
- o_mem_req  out  1  fetch request; memory samples o_mem_addr this cycle.
- o_mem_addr  out  ADDR_WIDTH  request address (= internal fetch PC).
- o_mem_write  out  1  constant 0.
- i_mem_ack  in  1  response valid for the single outstanding request.
- i_mem_data  in  WORD_WIDTH  response instruction, valid when i_mem_ack=1.
- o_next_pc  out  ADDR_WIDTH  next address fetch will request (fetch PC).
- o_valid  out  1  queue head holds an instruction.
- o_inst  out  WORD_WIDTH  head instruction; 0 when o_valid=0.
- o_inst_pc  out  ADDR_WIDTH  address of head instruction; 0 when o_valid=0.

## Operation
- State: fetch PC, queue (DEPTH x {pc, inst}, read/write pointers, count 0..DEPTH), outstanding bit, drop bit.
- At most one request in flight. o_mem_req = !i_rst && !i_flush && (!outstanding || (i_mem_ack && !drop)) && (count + outstanding < DEPTH) (combinational).
- Request accepted the cycle o_mem_req=1: outstanding<=1, request PC latched, fetch PC += WORD_WIDTH/8 (modulo 2^ADDR_WIDTH).
- Ack with outstanding=1, drop=0: push {request PC, i_mem_data}; outstanding clears unless a new request issues in the same cycle.
- Ack with drop=1: data discarded, drop<=0, outstanding<=0; no request in that cycle.
- Ack with outstanding=0: ignored (protocol error; no state change).
- Pop: o_valid && !i_stall; read pointer advances. Push and pop in the same cycle keep count unchanged, including at count=DEPTH.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH; the occupancy check counts the in-flight slot as reserved.
- Flush (priority over push, pop and request): count<=0, pointers<=0, fetch PC<=i_flush_pc, o_valid=0 next cycle. If outstanding and no ack this cycle: drop<=1, outstanding stays 1. If ack this cycle: response discarded, outstanding<=0, drop<=0.
- Repeated flush while drop=1: drop stays 1; fetch PC takes the latest i_flush_pc.
- Reset (overrides flush): fetch PC<=RESET_PC, count/pointers/outstanding/drop<=0. Any ack from a request issued before reset is ignored.

## Timing
- Reset values: o_valid=0, o_inst=0, o_inst_pc=0, o_mem_req=0 during reset, o_mem_write=0, o_next_pc=RESET_PC.
- First request in the first cycle after i_rst deasserts.
- Request at cycle T, ack at T+L (L>=1): entry visible (o_valid=1) at T+L+1.
- L=1 sustains one instruction per cycle (request issued in each ack cycle).
- o_inst/o_inst_pc are registered queue outputs; no memory-to-output combinational path.
- After flush at cycle F with no outstanding request: request to i_flush_pc at F+1. With an outstanding request: first request in the cycle after the discarded ack.

## Test plan
- Reset, then L=1 memory, i_stall=0: o_mem_req at cycles 1,2,3…, addresses 0,4,8; o_valid from cycle 3 with o_inst_pc 0,4,8 in consecutive cycles.
- DEPTH=4, i_stall=1, L=1: exactly 4 requests (0x0–0xC) issued, o_mem_req=0 afterwards. Release stall: pops 0,4,8,C in order; fetching resumes at 0x10.
- Full queue with i_stall=0 and ack in the same cycle: count stays 4; entries pushed after a pointer wrap are read back in address order.
- L=3, flush at the cycle after the request to 0x8, i_flush_pc=0x100: the ack for 0x8 is dropped; next request to 0x100; first o_valid entry has o_inst_pc=0x100.
- Flush in the same cycle as an ack: data discarded, o_valid=0, request to i_flush_pc issued the next cycle.
- i_rst asserted mid-stream with a request outstanding: outputs return to reset values; the stale ack is ignored; fetch restarts at RESET_PC.
